// File: rtl/uart_ts_pkg.sv
// Shared widths, constants and the stamp payload for the UART time-stamp generator.
package uart_ts_pkg;

  localparam int unsigned ACQ_W      = 4;
  localparam int unsigned MS_W       = 12;
  localparam int unsigned SEC_W      = 32;
  localparam int unsigned PRESC_W    = 16;
  localparam int unsigned MS_PER_SEC = 1000;
  localparam int unsigned MS_HALF    = 500;

  typedef struct packed {
    logic [ACQ_W-1:0] acq;
    logic [MS_W-1:0]  ms;
    logic [SEC_W-1:0] sec;
  } ts_stamp_t;

endpackage

// File: rtl/ts_pps_sync.sv
// Two-flop synchronizer for the asynchronous PPS pin plus rising-edge detect.
module ts_pps_sync (
  input  logic clk,
  input  logic rst,
  input  logic pps_i,
  output logic pps_edge_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pps_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // High for exactly one cycle after the synchronized level rises.
  assign pps_edge_c = sync_q & ~prev_q;

endmodule

// File: rtl/uart_timestamp_gen.sv
// Free-running sub-ms / ms / seconds stamp source with host load and optional PPS alignment
// (PPS alignment enabled by defining TIMESTAMP_PPS_SYNC_EN).
module uart_timestamp_gen
  import uart_ts_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 4000,
  parameter int unsigned TICK_PER_MS  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_Enable_i,
  input  logic             p_TimeSet_i,
  input  logic [SEC_W-1:0] SecondSet_i,
  input  logic             p_Pps_i,
  output logic [ACQ_W-1:0] acqurate_stamp_o,
  output logic [MS_W-1:0]  millisecond_stamp_o,
  output logic [SEC_W-1:0] second_stamp_o,
  output logic             p_MsTick_o,
  output logic             p_SecTick_o,
  output logic             p_PpsSeen_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  ts_stamp_t          stamp_q, stamp_d;
  logic               ms_tick_q, ms_tick_d;
  logic               sec_tick_q, sec_tick_d;
  logic               pps_seen_q, pps_seen_d;
  logic               pps_edge_c;
  logic               presc_wrap_c;
  logic               acq_wrap_c;
  logic               ms_wrap_c;
  logic               ms_late_half_c;

`ifdef TIMESTAMP_PPS_SYNC_EN
  ts_pps_sync u_pps_sync (
    .clk        (clk),
    .rst        (rst),
    .pps_i      (p_Pps_i),
    .pps_edge_c (pps_edge_c)
  );
`else
  logic unused_pps_c;
  assign unused_pps_c = p_Pps_i;
  assign pps_edge_c   = 1'b0;
`endif

  assign presc_wrap_c   = (presc_q == PRESC_W'(CLK_PER_TICK - 1));
  assign acq_wrap_c     = (stamp_q.acq == ACQ_W'(TICK_PER_MS - 1));
  assign ms_wrap_c      = (stamp_q.ms == MS_W'(MS_PER_SEC - 1));
  assign ms_late_half_c = (stamp_q.ms >= MS_W'(MS_HALF));

  // Priority: host load, then PPS alignment, then normal cascaded counting.
  always_comb begin
    presc_d    = presc_q;
    stamp_d    = stamp_q;
    ms_tick_d  = 1'b0;
    sec_tick_d = 1'b0;
    pps_seen_d = pps_seen_q;

    if (p_TimeSet_i) begin
      presc_d     = '0;
      stamp_d.acq = '0;
      stamp_d.ms  = '0;
      stamp_d.sec = SecondSet_i;
      sec_tick_d  = 1'b1;
    end else if (pps_edge_c) begin
      presc_d     = '0;
      stamp_d.acq = '0;
      stamp_d.ms  = '0;
      // Past mid-second the pulse belongs to the next second.
      if (ms_late_half_c) begin
        stamp_d.sec = stamp_q.sec + SEC_W'(1);
      end
      sec_tick_d  = 1'b1;
      pps_seen_d  = 1'b1;
    end else if (p_Enable_i) begin
      if (presc_wrap_c) begin
        presc_d = '0;
        if (acq_wrap_c) begin
          stamp_d.acq = '0;
          ms_tick_d   = 1'b1;
          if (ms_wrap_c) begin
            stamp_d.ms  = '0;
            stamp_d.sec = stamp_q.sec + SEC_W'(1);
            sec_tick_d  = 1'b1;
          end else begin
            stamp_d.ms = stamp_q.ms + MS_W'(1);
          end
        end else begin
          stamp_d.acq = stamp_q.acq + ACQ_W'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q    <= '0;
      stamp_q    <= '0;
      ms_tick_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      pps_seen_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      stamp_q    <= stamp_d;
      ms_tick_q  <= ms_tick_d;
      sec_tick_q <= sec_tick_d;
      pps_seen_q <= pps_seen_d;
    end
  end

  assign acqurate_stamp_o    = stamp_q.acq;
  assign millisecond_stamp_o = stamp_q.ms;
  assign second_stamp_o      = stamp_q.sec;
  assign p_MsTick_o          = ms_tick_q;
  assign p_SecTick_o         = sec_tick_q;
  assign p_PpsSeen_o         = pps_seen_q;

endmodule

// File: tb/tb_uart_timestamp_gen.sv
// Scoreboard bench for uart_timestamp_gen (CLK_PER_TICK=4, TICK_PER_MS=10).
module tb_uart_timestamp_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        timeset = 1'b0;
  logic [31:0] sec_set = 32'd0;
  logic        pps = 1'b0;
  logic [3:0]  acq;
  logic [11:0] ms;
  logic [31:0] sec;
  logic        ms_tick;
  logic        sec_tick;
  logic        pps_seen;

  always #5 clk = ~clk;

  uart_timestamp_gen #(.CLK_PER_TICK(4), .TICK_PER_MS(10)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .p_Enable_i          (en),
    .p_TimeSet_i         (timeset),
    .SecondSet_i         (sec_set),
    .p_Pps_i             (pps),
    .acqurate_stamp_o    (acq),
    .millisecond_stamp_o (ms),
    .second_stamp_o      (sec),
    .p_MsTick_o          (ms_tick),
    .p_SecTick_o         (sec_tick),
    .p_PpsSeen_o         (pps_seen)
  );

  typedef struct packed {
    logic [3:0]  acq;
    logic [11:0] ms;
    logic [31:0] sec;
    logic        mt;
    logic        st;
    logic        ps;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  chk_req = 1'b0;

  function automatic exp_t mk(input logic [3:0] a, input logic [11:0] m, input logic [31:0] s,
                              input logic mt, input logic st, input logic ps);
    exp_t e;
    e.acq = a; e.ms = m; e.sec = s; e.mt = mt; e.st = st; e.ps = ps;
    return e;
  endfunction

  task automatic push(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_now(input string nm, input exp_t e);
    push(nm, e);
    chk_req = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk_req = 1'b0;
    end
  endtask

  // Monitor: any tick pulse or explicit check request consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t  got;
    exp_t  e;
    string nm;
    if (chk_req || ms_tick === 1'b1 || sec_tick === 1'b1) begin
      got = {acq, ms, sec, ms_tick, sec_tick, pps_seen};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got acq=%0d ms=%0d sec=%0d mt=%b st=%b seen=%b with empty scoreboard",
                 got.acq, got.ms, got.sec, got.mt, got.st, got.ps);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL %s: got acq=%0d ms=%0d sec=%0d mt=%b st=%b seen=%b, expected acq=%0d ms=%0d sec=%0d mt=%b st=%b seen=%b",
                   nm, got.acq, got.ms, got.sec, got.mt, got.st, got.ps,
                   e.acq, e.ms, e.sec, e.mt, e.st, e.ps);
        end
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and first increments
    step(3);
    expect_now("reset", mk(4'd0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    step(3);
    expect_now("pre_first_acq", mk(4'd0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    step(1);
    expect_now("first_acq", mk(4'd1, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    push("first_ms", mk(4'd0, 12'd1, 32'd0, 1'b1, 1'b0, 1'b0));
    step(36);

    // Freeze at ms=5, acq=3, prescaler=2
    for (int m = 2; m <= 5; m++) push("ms_tick_a", mk(4'd0, 12'(m), 32'd0, 1'b1, 1'b0, 1'b0));
    step(160);
    step(12);
    step(2);
    en = 1'b0;
    expect_now("pre_freeze", mk(4'd3, 12'd5, 32'd0, 1'b0, 1'b0, 1'b0));
    step(100);
    en = 1'b1;
    expect_now("freeze_hold", mk(4'd3, 12'd5, 32'd0, 1'b0, 1'b0, 1'b0));
    step(1);
    expect_now("reenable_no_tick", mk(4'd3, 12'd5, 32'd0, 1'b0, 1'b0, 1'b0));
    step(1);
    expect_now("reenable_tick", mk(4'd4, 12'd5, 32'd0, 1'b0, 1'b0, 1'b0));

    // TimeSet mid-tick discards the partial tick
    step(2);
    timeset = 1'b1;
    sec_set = 32'd1234;
    push("timeset_1234", mk(4'd0, 12'd0, 32'd1234, 1'b0, 1'b1, 1'b0));
    step(1);
    timeset = 1'b0;
    step(3);
    expect_now("ts_no_acq_yet", mk(4'd0, 12'd0, 32'd1234, 1'b0, 1'b0, 1'b0));
    step(1);
    expect_now("ts_first_acq", mk(4'd1, 12'd0, 32'd1234, 1'b0, 1'b0, 1'b0));

    // Seconds rollover from 2^32-1
    timeset = 1'b1;
    sec_set = 32'hFFFF_FFFF;
    push("timeset_max", mk(4'd0, 12'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0));
    step(1);
    timeset = 1'b0;
    for (int m = 1; m <= 999; m++) push("ms_tick_b", mk(4'd0, 12'(m), 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
    step(39999);
    expect_now("pre_rollover", mk(4'd9, 12'd999, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    push("rollover", mk(4'd0, 12'd0, 32'd0, 1'b1, 1'b1, 1'b0));
    step(1);

`ifdef TIMESTAMP_PPS_SYNC_EN
    // Early PPS at ms=700 advances the second
    timeset = 1'b1;
    sec_set = 32'd10;
    push("timeset_10", mk(4'd0, 12'd0, 32'd10, 1'b0, 1'b1, 1'b0));
    step(1);
    timeset = 1'b0;
    for (int m = 1; m <= 700; m++) push("ms_tick_c", mk(4'd0, 12'(m), 32'd10, 1'b1, 1'b0, 1'b0));
    step(28000);
    pps = 1'b1;
    push("pps_early", mk(4'd0, 12'd0, 32'd11, 1'b0, 1'b1, 1'b1));
    step(3);
    pps = 1'b0;

    // Late PPS at ms=200 keeps the second
    for (int m = 1; m <= 200; m++) push("ms_tick_d", mk(4'd0, 12'(m), 32'd11, 1'b1, 1'b0, 1'b1));
    step(8000);
    pps = 1'b1;
    push("pps_late", mk(4'd0, 12'd0, 32'd11, 1'b0, 1'b1, 1'b1));
    step(3);
    pps = 1'b0;
    step(5);
    expect_now("pps_hold", mk(4'd1, 12'd0, 32'd11, 1'b0, 0, 1'b1));

    // PPS edge colliding with TimeSet is dropped
    pps = 1'b1;
    step(2);
    timeset = 1'b1;
    sec_set = 32'd50;
    push("collision", mk(4'd0, 12'd0, 32'd50, 1'b0, 1'b1, 1'b1));
    step(1);
    timeset = 1'b0;
    step(5);
    expect_now("collision_dropped", mk(4'd1, 12'd0, 32'd50, 1'b0, 1'b0, 1'b1));
    step(2);
`else
    // PPS pin has no effect when alignment is compiled out
    push("ms_tick_nopps", mk(4'd0, 12'd1, 32'd0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      pps = ~pps;
      step(4);
    end
    step(1);
    expect_now("pps_ignored", mk(4'd0, 12'd1, 32'd0, 1'b0, 1'b0, 1'b0));
    step(2);
`endif

    step(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0 (next: %s)",
               exp_q.size(), name_q[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
